wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Parametrised writeback arbiter between the execute units and the physical register file / commit stage. It buffers completed results per execute unit in small FIFOs and grants up to WB_PORTS results per cycle using round-robin arbitration, so there can be fewer register-file write ports than execute units. Execute units are back-pressured with a valid/ready handshake. A commit flush discards all buffered and in-flight results.

## Interface
- UNIT_NUM, 6: number of execute-unit input channels (≥1).
- WB_PORTS, 4: number of writeback output ports (1..UNIT_NUM).
- FIFO_DEPTH, 2: entries per unit FIFO (≥1).
- PHY_ID_WIDTH, 6: physical register id width.
- DATA_WIDTH, 32: register data width.
- ROB_ID_WIDTH, 5: ROB id width.

Ports (unit i occupies slice [i*W +: W]; port p likewise):
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  commit flush; this is enable & flush from the commit feedback.
- unit_valid  input  UNIT_NUM  result present.
- unit_ready  output  UNIT_NUM  unit FIFO can accept.
- unit_we  input  UNIT_NUM  result writes a physical register.
- unit_phy_id  input  UNIT_NUM*PHY_ID_WIDTH  destination physical register.
- unit_data  input  UNIT_NUM*DATA_WIDTH  result value.
- unit_rob_id  input  UNIT_NUM*ROB_ID_WIDTH  ROB entry to mark complete.
- wb_phyf_we  output  WB_PORTS  register-file write enable.
- wb_phyf_id  output  WB_PORTS*PHY_ID_WIDTH  write id.
- wb_phyf_data  output  WB_PORTS*DATA_WIDTH  write data.
- wb_done_valid  output  WB_PORTS  completion to commit.
- wb_done_rob_id  output  WB_PORTS*ROB_ID_WIDTH  completed ROB id.

## Operation
- **Per-unit FIFO.** Each unit has a FIFO of {we, phy_id, data, rob_id} with read/write pointers and an occupancy count of $clog2(FIFO_DEPTH+1) bits. Pointers wrap modulo FIFO_DEPTH.
- **Ready.** unit_ready[i] = (count[i] < FIFO_DEPTH) & !flush. It does not depend on unit_valid. A transfer occurs when valid & ready.
- **Candidates.** Unit i is a candidate if its FIFO is non-empty; its head is the payload. See Configuration for the bypass candidate.
- **Round-robin.** Register rr_ptr ∈ [0, UNIT_NUM-1].
  - Scan units starting at rr_ptr and wrapping. The first WB_PORTS candidates found are granted and assigned to ports 0,1,… in scan order.
  - If any unit is granted, rr_ptr ← (last granted index + 1) mod UNIT_NUM. Otherwise rr_ptr holds.
- **Granted head.** A granted FIFO head pops. A simultaneous push and pop on one FIFO leaves count unchanged.
- **Output registers.** For port p granted with entry e:
  - wb_phyf_we[p] ← e.we; wb_phyf_id/data[p] ← e.
  - wb_done_valid[p] ← 1; wb_done_rob_id[p] ← e.rob_id.
  - Entries with we=0 (stores, branches) still consume a port, with wb_phyf_we=0 and wb_done_valid=1.
  - Ungranted ports load we=0, done_valid=0. Their id/data/rob_id fields are don't-care and hold their previous values.
- **Flush** (has priority over everything):
  - No grants and no pushes in the flush cycle.
  - All counts and pointers are cleared at the next edge.
  - All output valid/we bits are 0 in the next cycle.
  - rr_ptr holds.

## Timing
- **Reset.** All outputs 0; all FIFOs empty; rr_ptr = 0. unit_ready = all-ones after reset, while flush = 0.
- **Latency without bypass.** Accept at cycle t, FIFO head visible at t+1, granted at t+1, outputs valid at t+2.
- **Latency with bypass.** An empty-FIFO result presented at t and granted at t appears on outputs at t+1.
- **Throughput.** At most one pop per unit per cycle; at most WB_PORTS grants per cycle.
- **Reset mid-operation.** Asynchronously empties the FIFOs and zeroes outputs and rr_ptr.
- **Boundary cases.**
  - A full FIFO gives unit_ready=0 in the same cycle the count reaches FIFO_DEPTH.
  - A full FIFO that is popped still shows ready=0 that cycle, because ready is count-based.
  - FIFO_DEPTH=1 must work: single entry, pointers constant 0.

## Configuration
- **WB_ARB_BYPASS_EN defined.**
  - A unit with an empty FIFO and unit_valid & unit_ready is also a candidate; its input is the payload.
  - If granted, it goes directly to the output registers and is not written to the FIFO.
  - If not granted, it is pushed normally.
  - Bypass candidates arbitrate in the same round-robin scan as FIFO heads.
- **WB_ARB_BYPASS_EN not defined.**
  - Only FIFO heads are candidates, so latency is fixed at 2.
  - Behaviour is otherwise identical.

## Test plan
- **Reset behaviour.** Hold rst=0 for 3 cycles, then release. Required: all outputs 0, unit_ready=6'b111111, rr_ptr=0.
- **Single result, no bypass.** Unit 2 sends we=1, id=5, data=0xDEADBEEF, rob=3 at cycle t. Required: at t+2, port 0 has wb_phyf_we=1, id=5, data=0xDEADBEEF, wb_done_rob_id=3.
  - With WB_ARB_BYPASS_EN, the same result appears at t+1.
- **Round-robin over the port limit.** All 6 units hold one entry each, WB_PORTS=4, rr_ptr=0.
  - Cycle 1 grants units 0–3 to ports 0–3; rr_ptr becomes 4.
  - Cycle 2 grants units 4 and 5 to ports 0 and 1.
- **Back-pressure.** Unit 1 streams valid=1 every cycle while other units keep ports busy so unit 1 is not granted. Required: after 2 accepts (FIFO_DEPTH=2), unit_ready[1]=0; it returns to 1 the cycle after unit 1's first pop.
- **Non-writing result.** Unit 0 sends we=0, rob=7. Required: wb_phyf_we[0]=0, wb_done_valid[0]=1, wb_done_rob_id[0]=7.
- **Flush with data in flight.** Units 0–5 each hold 2 entries; assert flush for one cycle. Required: the next cycle has all wb_phyf_we and wb_done_valid = 0, and all FIFOs are empty; unit_ready=0 during the flush cycle and all-ones afterwards.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-unit result FIFOs drained onto WB_PORTS register-file/commit ports in round-robin order.
// Define WB_ARB_BYPASS_EN to let a result arriving at an empty FIFO compete for a port in the same cycle.
module wb_arbiter #(
    parameter int UNIT_NUM     = 6,
    parameter int WB_PORTS     = 4,
    parameter int FIFO_DEPTH   = 2,
    parameter int PHY_ID_WIDTH = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int ROB_ID_WIDTH = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [UNIT_NUM-1:0]              unit_valid,
    output logic [UNIT_NUM-1:0]              unit_ready,
    input  logic [UNIT_NUM-1:0]              unit_we,
    input  logic [UNIT_NUM*PHY_ID_WIDTH-1:0] unit_phy_id,
    input  logic [UNIT_NUM*DATA_WIDTH-1:0]   unit_data,
    input  logic [UNIT_NUM*ROB_ID_WIDTH-1:0] unit_rob_id,
    output logic [WB_PORTS-1:0]              wb_phyf_we,
    output logic [WB_PORTS*PHY_ID_WIDTH-1:0] wb_phyf_id,
    output logic [WB_PORTS*DATA_WIDTH-1:0]   wb_phyf_data,
    output logic [WB_PORTS-1:0]              wb_done_valid,
    output logic [WB_PORTS*ROB_ID_WIDTH-1:0] wb_done_rob_id
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int RR_W  = (UNIT_NUM > 1) ? $clog2(UNIT_NUM) : 1;

    logic                    fifo_we   [UNIT_NUM][FIFO_DEPTH];
    logic [PHY_ID_WIDTH-1:0] fifo_id   [UNIT_NUM][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_data [UNIT_NUM][FIFO_DEPTH];
    logic [ROB_ID_WIDTH-1:0] fifo_rob  [UNIT_NUM][FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr    [UNIT_NUM];
    logic [PTR_W-1:0]        wr_ptr    [UNIT_NUM];
    logic [CNT_W-1:0]        count     [UNIT_NUM];

    logic [UNIT_NUM-1:0]     byp;
    logic [UNIT_NUM-1:0]     cand;
    logic [UNIT_NUM-1:0]     grant;
    logic [UNIT_NUM-1:0]     push;
    logic [UNIT_NUM-1:0]     pop;
    logic                    cand_we   [UNIT_NUM];
    logic [PHY_ID_WIDTH-1:0] cand_id   [UNIT_NUM];
    logic [DATA_WIDTH-1:0]   cand_data [UNIT_NUM];
    logic [ROB_ID_WIDTH-1:0] cand_rob  [UNIT_NUM];

    logic [RR_W-1:0]         rr_ptr;
    logic [RR_W-1:0]         rr_next;
    logic [WB_PORTS-1:0]     port_valid;
    logic [RR_W-1:0]         port_src  [WB_PORTS];
    logic [RR_W-1:0]         scan_u;
    int                      scan_idx;
    int                      n_grant;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready is purely occupancy-based, so a full FIFO stays not-ready even in a cycle it is popped.
    always_comb begin
        for (int i = 0; i < UNIT_NUM; i++) begin
            unit_ready[i] = (count[i] < CNT_W'(FIFO_DEPTH)) && !flush;
        end
    end

    always_comb begin
        for (int i = 0; i < UNIT_NUM; i++) begin
`ifdef WB_ARB_BYPASS_EN
            byp[i] = (count[i] == '0) && unit_valid[i] && unit_ready[i];
`else
            byp[i] = 1'b0;
`endif
            cand[i] = !flush && ((count[i] != '0) || byp[i]);
            if (byp[i]) begin
                cand_we[i]   = unit_we[i];
                cand_id[i]   = unit_phy_id[i*PHY_ID_WIDTH +: PHY_ID_WIDTH];
                cand_data[i] = unit_data[i*DATA_WIDTH +: DATA_WIDTH];
                cand_rob[i]  = unit_rob_id[i*ROB_ID_WIDTH +: ROB_ID_WIDTH];
            end else begin
                cand_we[i]   = fifo_we[i][rd_ptr[i]];
                cand_id[i]   = fifo_id[i][rd_ptr[i]];
                cand_data[i] = fifo_data[i][rd_ptr[i]];
                cand_rob[i]  = fifo_rob[i][rd_ptr[i]];
            end
        end
    end

    // Rotating scan from rr_ptr; the k-th candidate found takes port k.
    always_comb begin
        grant      = '0;
        port_valid = '0;
        rr_next    = rr_ptr;
        n_grant    = 0;
        scan_idx   = 0;
        scan_u     = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            port_src[p] = '0;
        end
        for (int k = 0; k < UNIT_NUM; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= UNIT_NUM) begin
                scan_idx = scan_idx - UNIT_NUM;
            end
            scan_u = RR_W'(scan_idx);
            if (cand[scan_u] && (n_grant < WB_PORTS)) begin
                grant[scan_u] = 1'b1;
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (n_grant == p) begin
                        port_valid[p] = 1'b1;
                        port_src[p]   = scan_u;
                    end
                end
                n_grant = n_grant + 1;
                rr_next = (scan_idx == UNIT_NUM - 1) ? '0 : RR_W'(scan_idx + 1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < UNIT_NUM; i++) begin
            push[i] = unit_valid[i] && unit_ready[i] && !(grant[i] && byp[i]);
            pop[i]  = grant[i] && !byp[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < UNIT_NUM; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < UNIT_NUM; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < UNIT_NUM; i++) begin
                if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                if (push[i] && !pop[i])      count[i] <= count[i] + CNT_W'(1);
                else if (!push[i] && pop[i]) count[i] <= count[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < UNIT_NUM; i++) begin
            if (push[i]) begin
                fifo_we[i][wr_ptr[i]]   <= unit_we[i];
                fifo_id[i][wr_ptr[i]]   <= unit_phy_id[i*PHY_ID_WIDTH +: PHY_ID_WIDTH];
                fifo_data[i][wr_ptr[i]] <= unit_data[i*DATA_WIDTH +: DATA_WIDTH];
                fifo_rob[i][wr_ptr[i]]  <= unit_rob_id[i*ROB_ID_WIDTH +: ROB_ID_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_ptr <= '0;
        else if (!flush) rr_ptr <= rr_next;
    end

    // Ungranted ports keep their payload fields; only the valid/we bits are cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_phyf_we     <= '0;
            wb_phyf_id     <= '0;
            wb_phyf_data   <= '0;
            wb_done_valid  <= '0;
            wb_done_rob_id <= '0;
        end else begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (port_valid[p]) begin
                    wb_phyf_we[p]                                    <= cand_we[port_src[p]];
                    wb_phyf_id[p*PHY_ID_WIDTH +: PHY_ID_WIDTH]       <= cand_id[port_src[p]];
                    wb_phyf_data[p*DATA_WIDTH +: DATA_WIDTH]         <= cand_data[port_src[p]];
                    wb_done_valid[p]                                 <= 1'b1;
                    wb_done_rob_id[p*ROB_ID_WIDTH +: ROB_ID_WIDTH]   <= cand_rob[port_src[p]];
                end else begin
                    wb_phyf_we[p]    <= 1'b0;
                    wb_done_valid[p] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts each cycle's port outputs,
// and an independent monitor compares them one clock later. Honours WB_ARB_BYPASS_EN like the DUT.
module tb_wb_arbiter;
    localparam int N  = 6;
    localparam int P  = 4;
    localparam int D  = 2;
    localparam int IW = 6;
    localparam int DW = 32;
    localparam int RW = 5;
`ifdef WB_ARB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic          we;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [RW-1:0] rob;
    } ent_t;

    typedef struct {
        int   port;
        ent_t e;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            flush;
    logic [N-1:0]    unit_valid;
    logic [N-1:0]    unit_ready;
    logic [N-1:0]    unit_we;
    logic [N*IW-1:0] unit_phy_id;
    logic [N*DW-1:0] unit_data;
    logic [N*RW-1:0] unit_rob_id;
    logic [P-1:0]    wb_phyf_we;
    logic [P*IW-1:0] wb_phyf_id;
    logic [P*DW-1:0] wb_phyf_data;
    logic [P-1:0]    wb_done_valid;
    logic [P*RW-1:0] wb_done_rob_id;

    ent_t st [N];
    ent_t mq [N][$];
    exp_t exp_q [$];
    int   rr_m;
    int   checks;
    int   passes;

    wb_arbiter #(
        .UNIT_NUM(N), .WB_PORTS(P), .FIFO_DEPTH(D),
        .PHY_ID_WIDTH(IW), .DATA_WIDTH(DW), .ROB_ID_WIDTH(RW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_we(unit_we),
        .unit_phy_id(unit_phy_id), .unit_data(unit_data), .unit_rob_id(unit_rob_id),
        .wb_phyf_we(wb_phyf_we), .wb_phyf_id(wb_phyf_id), .wb_phyf_data(wb_phyf_data),
        .wb_done_valid(wb_done_valid), .wb_done_rob_id(wb_done_rob_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic randomPayload();
        for (int i = 0; i < N; i++) begin
            st[i].we   = 1'($urandom_range(0, 1));
            st[i].id   = IW'($urandom);
            st[i].data = $urandom;
            st[i].rob  = RW'($urandom);
        end
    endtask

    // Drives one cycle of inputs, checks ready, and advances the reference model through that cycle's edge.
    task automatic applyStimulus(input logic [N-1:0] valid, input logic fl);
        logic [N-1:0] rdy_m;
        logic [N-1:0] byp_taken;
        int           granted;
        int           last;
        int           u;
        bit           head;
        bit           byp;
        exp_t         x;
        @(negedge clk);
        unit_valid = valid;
        flush      = fl;
        for (int i = 0; i < N; i++) begin
            unit_we[i]              = st[i].we;
            unit_phy_id[i*IW +: IW] = st[i].id;
            unit_data[i*DW +: DW]   = st[i].data;
            unit_rob_id[i*RW +: RW] = st[i].rob;
        end
        #1;
        for (int i = 0; i < N; i++) begin
            rdy_m[i] = !fl && (mq[i].size() < D);
        end
        checks++;
        if (unit_ready === rdy_m) passes++;
        else $display("[TB] FAIL ready: got %b required %b at %0t", unit_ready, rdy_m, $time);
        if (fl) begin
            for (int i = 0; i < N; i++) mq[i].delete();
        end else begin
            granted   = 0;
            last      = -1;
            byp_taken = '0;
            for (int k = 0; k < N; k++) begin
                u    = (rr_m + k) % N;
                head = (mq[u].size() > 0);
                byp  = BYPASS && !head && valid[u] && rdy_m[u];
                if ((head || byp) && granted < P) begin
                    x.port = granted;
                    if (head) begin
                        x.e = mq[u][0];
                        void'(mq[u].pop_front());
                    end else begin
                        x.e = st[u];
                        byp_taken[u] = 1'b1;
                    end
                    exp_q.push_back(x);
                    granted++;
                    last = u;
                end
            end
            if (last >= 0) rr_m = (last + 1) % N;
            for (int i = 0; i < N; i++) begin
                if (valid[i] && rdy_m[i] && !byp_taken[i]) mq[i].push_back(st[i]);
            end
        end
    endtask

    task automatic resetDut(input int cycles);
        @(negedge clk);
        rst        = 1'b0;
        unit_valid = '0;
        flush      = 1'b0;
        #1;
        checks++;
        if ({wb_phyf_we, wb_phyf_id, wb_phyf_data, wb_done_valid, wb_done_rob_id} === '0) passes++;
        else $display("[TB] FAIL reset_outputs: got we=%b valid=%b data=%h required all zero",
                      wb_phyf_we, wb_done_valid, wb_phyf_data);
        checks++;
        if (unit_ready === {N{1'b1}}) passes++;
        else $display("[TB] FAIL reset_ready: got %b required %b", unit_ready, {N{1'b1}});
        for (int i = 0; i < N; i++) mq[i].delete();
        exp_q.delete();
        rr_m = 0;
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
    endtask

    // Everything queued by the model was predicted for the edge that just passed.
    task automatic checkOutput();
        int                       idx;
        logic [2+IW+DW+RW-1:0]    act;
        logic [2+IW+DW+RW-1:0]    req;
        for (int p = 0; p < P; p++) begin
            idx = -1;
            foreach (exp_q[j]) if (exp_q[j].port == p) idx = j;
            act = {wb_done_valid[p], wb_phyf_we[p], wb_phyf_id[p*IW +: IW],
                   wb_phyf_data[p*DW +: DW], wb_done_rob_id[p*RW +: RW]};
            checks++;
            if (idx >= 0) begin
                req = {1'b1, exp_q[idx].e.we, exp_q[idx].e.id, exp_q[idx].e.data, exp_q[idx].e.rob};
                if (act === req) passes++;
                else $display("[TB] FAIL port%0d: got v=%b we=%b id=%0d data=%h rob=%0d required v=1 we=%b id=%0d data=%h rob=%0d at %0t",
                              p, act[2+IW+DW+RW-1], act[IW+DW+RW], act[IW+DW+RW-1 -: IW], act[DW+RW-1 -: DW], act[RW-1:0],
                              req[IW+DW+RW], req[IW+DW+RW-1 -: IW], req[DW+RW-1 -: DW], req[RW-1:0], $time);
            end else begin
                if (wb_done_valid[p] === 1'b0 && wb_phyf_we[p] === 1'b0) passes++;
                else $display("[TB] FAIL port%0d_idle: got v=%b we=%b required v=0 we=0 at %0t",
                              p, wb_done_valid[p], wb_phyf_we[p], $time);
            end
        end
        exp_q.delete();
    endtask

    always @(posedge clk) begin
        #1;
        checkOutput();
    end

    initial begin
        logic [N-1:0] mask;
        logic         fl;
        checks      = 0;
        passes      = 0;
        rr_m        = 0;
        rst         = 1'b1;
        flush       = 1'b0;
        unit_valid  = '0;
        unit_we     = '0;
        unit_phy_id = '0;
        unit_data   = '0;
        unit_rob_id = '0;
        randomPayload();
        #1 rst = 1'b0;
        resetDut(3);

        $display("[TB] single result from unit 2");
        st[2].we = 1'b1; st[2].id = 6'd5; st[2].data = 32'hDEADBEEF; st[2].rob = 5'd3;
        applyStimulus(6'b000100, 1'b0);
        repeat (3) applyStimulus('0, 1'b0);

        $display("[TB] round-robin beyond port count");
        resetDut(1);
        randomPayload();
        applyStimulus(6'b111111, 1'b0);
        repeat (3) applyStimulus('0, 1'b0);

        $display("[TB] back-pressure with all units streaming");
        for (int c = 0; c < 8; c++) begin
            randomPayload();
            applyStimulus(6'b111111, 1'b0);
        end
        repeat (4) applyStimulus('0, 1'b0);

        $display("[TB] non-writing result");
        st[0].we = 1'b0; st[0].rob = 5'd7;
        applyStimulus(6'b000001, 1'b0);
        repeat (3) applyStimulus('0, 1'b0);

        $display("[TB] flush with full FIFOs");
        for (int c = 0; c < 4; c++) begin
            randomPayload();
            applyStimulus(6'b111111, 1'b0);
        end
        randomPayload();
        applyStimulus(6'b111111, 1'b1);
        repeat (2) applyStimulus('0, 1'b0);
        randomPayload();
        applyStimulus(6'b100000, 1'b0);
        repeat (3) applyStimulus('0, 1'b0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            if (c == 200) resetDut(2);
            randomPayload();
            mask = N'($urandom) | N'($urandom);
            fl   = ($urandom_range(0, 24) == 0);
            applyStimulus(mask, fl);
        end
        repeat (5) applyStimulus('0, 1'b0);
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
